// File: rtl/core_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_cache_arbiter
// Description : Front end between NUM_PORTS core-side requesters and a single
//               data cache controller. Each port request is captured into a
//               holding register, pending requests are arbitrated and issued
//               one at a time, and completion / read data / stall are
//               returned per port.
//               Optional build macro CCI_ROUND_ROBIN_EN selects round-robin
//               grant; without it the lowest pending port index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module core_cache_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32
) (
  input  logic                        clock,
  input  logic                        cpu_reset,
  input  logic [NUM_PORTS-1:0]        req_en,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wd,
  output logic [NUM_PORTS*DATA_W-1:0] req_rd,
  output logic [NUM_PORTS-1:0]        req_stall,
  output logic                        cache_en,
  output logic                        cache_we,
  output logic [ADDR_W-1:0]           cache_addr,
  output logic [DATA_W-1:0]           cache_wd,
  input  logic [DATA_W-1:0]           cache_rd,
  input  logic                        cache_idle
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               state;
  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] hold_we;
  logic [ADDR_W-1:0]    hold_addr [NUM_PORTS];
  logic [DATA_W-1:0]    hold_wd   [NUM_PORTS];
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_we;
  logic [ADDR_W-1:0]    grant_addr;
  logic [DATA_W-1:0]    grant_wd;
  logic                 start;
  logic                 complete;
  logic [NUM_PORTS-1:0] clear_vec;

  // A new operation may start only when the cache reports idle
  assign start     = (state == ST_IDLE) && (|pending) && cache_idle;
  // The cache drops idle after the issue strobe, so idle in WAIT means done
  assign complete  = (state == ST_WAIT) && cache_idle;
  assign req_stall = pending;

  // Decode the completing port into a one-hot clear vector
  always_comb begin
    clear_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (complete && (winner == PTR_W'(i))) begin
        clear_vec[i] = 1'b1;
      end
    end
  end

`ifdef CCI_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr;
  logic             rr_hi_found;
  logic [PTR_W-1:0] rr_hi_idx;
  logic [PTR_W-1:0] rr_lo_idx;

  // Rotating priority: lowest pending port above the last grant, else wrap to lowest pending
  always_comb begin
    rr_hi_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        rr_lo_idx = PTR_W'(i);
        if (i > int'(rr_ptr)) begin
          rr_hi_found = 1'b1;
          rr_hi_idx   = PTR_W'(i);
        end
      end
    end
    grant_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
  end

  // Last-granted pointer, starting at the top port so port 0 is searched first
  always_ff @(posedge clock or posedge cpu_reset) begin
    if (cpu_reset) begin
      rr_ptr <= PTR_W'(NUM_PORTS - 1);
    end else if (start) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  // Fixed priority: the lowest pending port index wins
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end
`endif

  // Select the holding register of the granted port
  always_comb begin
    grant_we   = 1'b0;
    grant_addr = '0;
    grant_wd   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        grant_we   = hold_we[i];
        grant_addr = hold_addr[i];
        grant_wd   = hold_wd[i];
      end
    end
  end

  // Per-port capture, pending flags and read-data return
  always_ff @(posedge clock or posedge cpu_reset) begin
    if (cpu_reset) begin
      pending <= '0;
      hold_we <= '0;
      req_rd  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        hold_addr[i] <= '0;
        hold_wd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (clear_vec[i]) begin
          // A completing port is still pending, so no capture can collide here
          pending[i] <= 1'b0;
          if (!cache_we) begin
            req_rd[i*DATA_W +: DATA_W] <= cache_rd;
          end
        end else if (req_en[i] && !pending[i]) begin
          pending[i]   <= 1'b1;
          hold_we[i]   <= req_we[i];
          hold_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
          hold_wd[i]   <= req_wd[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Issue FSM: cache address/data/we only load on the IDLE->ISSUE edge
  always_ff @(posedge clock or posedge cpu_reset) begin
    if (cpu_reset) begin
      state      <= ST_IDLE;
      cache_en   <= 1'b0;
      cache_we   <= 1'b0;
      cache_addr <= '0;
      cache_wd   <= '0;
      winner     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cache_en   <= 1'b1;
            cache_we   <= grant_we;
            cache_addr <= grant_addr;
            cache_wd   <= grant_wd;
            winner     <= grant_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cache_en <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cache_idle) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          cache_en <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
